// File: rtl/sump_cmd_ctrl.sv
// sump_cmd_ctrl: SUMP frame decoder, capture config registers, arm handshake and ID reply sequencer
module sump_cmd_ctrl #(
  parameter logic [31:0] ID_WORD = 32'h31414C53
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [39:0] cmd_i,
  input  logic        stb_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_stb_o,
  input  logic        tx_rdy_i,
  output logic        soft_rst_o,
  output logic        arm_o,
  input  logic        done_i,
  output logic [31:0] trg_mask_o,
  output logic [31:0] trg_val_o,
  output logic [31:0] trg_cfg_o,
  output logic [23:0] div_o,
  output logic [15:0] read_cnt_o,
  output logic [15:0] delay_cnt_o,
  output logic [7:0]  flags_o,
  output logic        xoff_o,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, ARMED, ID_TX} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] op;
  logic [31:0] arg, id_sh;
  logic lng, sc, lc, rst_cmd, run_cmd, id_cmd, xon_cmd, xoff_cmd, hs;
  assign lng = cmd_i[7];
  assign op = lng ? cmd_i[7:0] : cmd_i[39:32];
  assign arg = cmd_i[39:8];
  assign sc = stb_i && !lng;
  // configuration is frozen while a capture is armed
  assign lc = stb_i && lng && state_q != ARMED;
  assign rst_cmd = sc && op == 8'h00;
  assign run_cmd = sc && op == 8'h01;
  assign id_cmd = sc && op == 8'h02;
  assign xon_cmd = sc && op == 8'h11;
  assign xoff_cmd = sc && op == 8'h13;
  assign hs = state_q == ID_TX && tx_rdy_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    if (rst_cmd) begin
      state_d = IDLE;
      idx_d = 2'd0;
    end else if (state_q == IDLE && run_cmd) begin
      state_d = ARMED;
    end else if (state_q == IDLE && id_cmd) begin
      state_d = ID_TX;
      idx_d = 2'd0;
    end else if (state_q == ARMED && done_i) begin
      state_d = IDLE;
    end else if (hs) begin
      state_d = idx_q == 2'd3 ? IDLE : ID_TX;
      idx_d = idx_q + 2'd1;
    end
  end
  // byte idx is sent MSB first, so shift by 8*(3-idx)
  always_comb id_sh = ID_WORD >> {~idx_d, 3'b000};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_o <= 1'b0;
      tx_stb_o <= 1'b0;
      busy_o <= 1'b0;
      soft_rst_o <= 1'b0;
      tx_data_o <= ID_WORD[31:24];
    end else begin
      arm_o <= state_d == ARMED;
      tx_stb_o <= state_d == ID_TX;
      busy_o <= state_d != IDLE;
      soft_rst_o <= rst_cmd;
      tx_data_o <= id_sh[7:0];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || rst_cmd) begin
      trg_mask_o <= '0;
      trg_val_o <= '0;
      trg_cfg_o <= '0;
      div_o <= '0;
      read_cnt_o <= '0;
      delay_cnt_o <= '0;
      flags_o <= '0;
      xoff_o <= 1'b0;
    end else begin
      xoff_o <= xoff_cmd ? 1'b1 : xon_cmd ? 1'b0 : xoff_o;
      if (lc && op == 8'hC0) trg_mask_o <= arg;
      if (lc && op == 8'hC1) trg_val_o <= arg;
      if (lc && op == 8'hC2) trg_cfg_o <= arg;
      if (lc && op == 8'h80) div_o <= arg[23:0];
      if (lc && op == 8'h81) {delay_cnt_o, read_cnt_o} <= arg;
      if (lc && op == 8'h82) flags_o <= arg[7:0];
    end
  end
endmodule

// File: tb/tb_sump_cmd_ctrl.sv
// tb_sump_cmd_ctrl: directed and randomized checks of sump_cmd_ctrl against a behavioural model
module tb_sump_cmd_ctrl;
  localparam logic [31:0] ID = 32'h31414C53;
  logic clk_i = 0, rst_i = 0, stb_i = 0, tx_rdy_i = 0, done_i = 0;
  logic [39:0] cmd_i = '0;
  logic [7:0] tx_data_o, flags_o;
  logic tx_stb_o, soft_rst_o, arm_o, xoff_o, busy_o;
  logic [31:0] trg_mask_o, trg_val_o, trg_cfg_o;
  logic [23:0] div_o;
  logic [15:0] read_cnt_o, delay_cnt_o;
  int checks = 0, errors = 0;
  int m_mode, m_idx;
  logic [31:0] m_mask, m_val, m_cfg;
  logic [23:0] m_div;
  logic [15:0] m_rc, m_dc;
  logic [7:0] m_flags;
  logic m_xoff, m_soft;
  logic [7:0] sent[$];
  logic [12:0] dut_ctl;
  logic [159:0] dut_cfg;
  sump_cmd_ctrl #(.ID_WORD(ID)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_i(cmd_i), .stb_i(stb_i),
    .tx_data_o(tx_data_o), .tx_stb_o(tx_stb_o), .tx_rdy_i(tx_rdy_i),
    .soft_rst_o(soft_rst_o), .arm_o(arm_o), .done_i(done_i),
    .trg_mask_o(trg_mask_o), .trg_val_o(trg_val_o), .trg_cfg_o(trg_cfg_o),
    .div_o(div_o), .read_cnt_o(read_cnt_o), .delay_cnt_o(delay_cnt_o),
    .flags_o(flags_o), .xoff_o(xoff_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  assign dut_ctl = {arm_o, tx_stb_o, busy_o, xoff_o, soft_rst_o, tx_stb_o ? tx_data_o : 8'h00};
  assign dut_cfg = {trg_mask_o, trg_val_o, trg_cfg_o, div_o, read_cnt_o, delay_cnt_o, flags_o};
  function automatic logic [7:0] id_byte(input int i);
    logic [31:0] w = ID;
    return w[31-8*i -: 8];
  endfunction
  function automatic logic [12:0] exp_ctl();
    return {m_mode == 1, m_mode == 2, m_mode != 0, m_xoff, m_soft, m_mode == 2 ? id_byte(m_idx) : 8'h00};
  endfunction
  function automatic logic [159:0] exp_cfg();
    return {m_mask, m_val, m_cfg, m_div, m_rc, m_dc, m_flags};
  endfunction
  task automatic m_clear();
    m_mode = 0; m_idx = 0; m_xoff = 0;
    m_mask = 0; m_val = 0; m_cfg = 0; m_div = 0; m_rc = 0; m_dc = 0; m_flags = 0;
  endtask
  // mode 0 idle, 1 capture armed, 2 sending ID byte m_idx
  task automatic m_step(input logic r, input logic s, input logic [39:0] c, input logic rdy, input logic d);
    logic lg;
    logic [7:0] op;
    logic [31:0] a;
    lg = c[7];
    op = lg ? c[7:0] : c[39:32];
    a = c[39:8];
    if (r) begin
      m_clear();
      m_soft = 0;
      return;
    end
    m_soft = s && !lg && op == 8'h00;
    if (m_soft) begin
      m_clear();
      return;
    end
    if (s && !lg && op == 8'h11) m_xoff = 0;
    if (s && !lg && op == 8'h13) m_xoff = 1;
    if (s && lg && m_mode != 1) begin
      if (op == 8'hC0) m_mask = a;
      if (op == 8'hC1) m_val = a;
      if (op == 8'hC2) m_cfg = a;
      if (op == 8'h80) m_div = a[23:0];
      if (op == 8'h81) begin m_rc = a[15:0]; m_dc = a[31:16]; end
      if (op == 8'h82) m_flags = a[7:0];
    end
    if (m_mode == 0 && s && !lg && op == 8'h01) m_mode = 1;
    else if (m_mode == 0 && s && !lg && op == 8'h02) begin m_mode = 2; m_idx = 0; end
    else if (m_mode == 1 && d) m_mode = 0;
    else if (m_mode == 2 && rdy) begin
      if (m_idx == 3) begin m_mode = 0; m_idx = 0; end
      else m_idx++;
    end
  endtask
  task automatic drive(input logic r, input logic s, input logic [39:0] c, input logic rdy, input logic d);
    rst_i = r; stb_i = s; cmd_i = c; tx_rdy_i = rdy; done_i = d;
    if (tx_stb_o && rdy && !r) sent.push_back(tx_data_o);
    m_step(r, s, c, rdy, d);
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    drive(1, 1, 40'h01_00000000, 1, 1);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (tx_data_o !== 8'h31) begin errors++; $display("FAIL reset_tx_data got %h want 31", tx_data_o); end
    checks++;
    if ({arm_o, tx_stb_o, busy_o, xoff_o, soft_rst_o} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {arm_o, tx_stb_o, busy_o, xoff_o, soft_rst_o}); end
    checks++;
    if (dut_cfg !== '0) begin errors++; $display("FAIL reset_cfg got %h want 0", dut_cfg); end
    drive(0, 0, 0, 0, 0);
  endtask
  task automatic test_config();
    drive(0, 1, 40'hDEADBEEF_C0, 0, 0);
    checks++;
    if (trg_mask_o !== 32'hDEADBEEF) begin errors++; $display("FAIL cfg_mask got %h want deadbeef", trg_mask_o); end
    checks++;
    if (dut_cfg !== exp_cfg() || dut_ctl !== exp_ctl()) begin errors++; $display("FAIL cfg_others got %h/%h want %h/%h", dut_cfg, dut_ctl, exp_cfg(), exp_ctl()); end
    drive(0, 1, 40'h00100020_81, 0, 0);
    drive(0, 1, 40'hFF000123_80, 0, 0);
    checks++;
    if ({read_cnt_o, delay_cnt_o, div_o} !== {16'h0020, 16'h0010, 24'h000123}) begin errors++; $display("FAIL cfg_cnt_div got %h %h %h want 0020 0010 000123", read_cnt_o, delay_cnt_o, div_o); end
    drive(0, 1, 40'h12345678_C2, 0, 0);
    drive(0, 1, 40'h000000A5_82, 0, 0);
    checks++;
    if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL cfg_c2_82 got %h want %h", dut_cfg, exp_cfg()); end
  endtask
  task automatic test_id();
    logic rp[5] = '{1, 0, 1, 1, 1};
    drive(0, 1, 40'h02_00000000, 0, 0);
    checks++;
    if ({tx_stb_o, busy_o, tx_data_o} !== {2'b11, 8'h31}) begin errors++; $display("FAIL id_start got %b%b %h want 11 31", tx_stb_o, busy_o, tx_data_o); end
    sent.delete();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, rp[i], 0);
      checks++;
      if (dut_ctl !== exp_ctl()) begin errors++; $display("FAIL id_step%0d got %h want %h", i, dut_ctl, exp_ctl()); end
    end
    checks++;
    if (sent.size() != 4 || sent[0] !== 8'h31 || sent[1] !== 8'h41 || sent[2] !== 8'h4C || sent[3] !== 8'h53)
      begin errors++; $display("FAIL id_bytes got %p want 31 41 4c 53", sent); end
    checks++;
    if (busy_o !== 1'b0 || tx_stb_o !== 1'b0) begin errors++; $display("FAIL id_end got busy %b stb %b want 0 0", busy_o, tx_stb_o); end
  endtask
  task automatic test_arm();
    drive(0, 1, 40'h01_00000000, 0, 0);
    drive(0, 1, 40'h00000005_C1, 0, 0);
    drive(0, 1, 40'h01_00000000, 0, 0);
    checks++;
    if (arm_o !== 1'b1 || trg_val_o !== 32'h0) begin errors++; $display("FAIL arm_hold got arm %b val %h want 1 0", arm_o, trg_val_o); end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (arm_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL arm_done got arm %b busy %b want 0 0", arm_o, busy_o); end
    drive(0, 0, 0, 1, 1);
    checks++;
    if (dut_ctl !== exp_ctl() || dut_cfg !== exp_cfg()) begin errors++; $display("FAIL done_idle got %h want %h", dut_ctl, exp_ctl()); end
  endtask
  task automatic test_reset_cmd();
    drive(0, 1, 40'h000000FF_C0, 0, 0);
    drive(0, 1, 40'h13_00000000, 0, 0);
    drive(0, 1, 40'h02_00000000, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({xoff_o, tx_stb_o, trg_mask_o} !== {2'b11, 32'hFF}) begin errors++; $display("FAIL rcmd_pre got %b%b %h want 11 ff", xoff_o, tx_stb_o, trg_mask_o); end
    drive(0, 1, 40'h00_00000000, 0, 0);
    checks++;
    if ({soft_rst_o, xoff_o, tx_stb_o, busy_o, trg_mask_o} !== {4'b1000, 32'h0}) begin errors++; $display("FAIL rcmd got %b%b%b%b %h want 1000 0", soft_rst_o, xoff_o, tx_stb_o, busy_o, trg_mask_o); end
    drive(0, 0, 0, 1, 0);
    checks++;
    if (soft_rst_o !== 1'b0 || tx_stb_o !== 1'b0) begin errors++; $display("FAIL rcmd_pulse got soft %b stb %b want 0 0", soft_rst_o, tx_stb_o); end
  endtask
  task automatic test_simultaneous();
    drive(0, 1, 40'h01_00000000, 0, 0);
    drive(0, 1, 40'h00_00000000, 0, 1);
    checks++;
    if ({soft_rst_o, arm_o} !== 2'b10) begin errors++; $display("FAIL rst_done got %b want 10", {soft_rst_o, arm_o}); end
    drive(0, 1, 40'h01_00000000, 0, 0);
    drive(0, 1, 40'h12345678_C0, 0, 1);
    checks++;
    if (arm_o !== 1'b0 || trg_mask_o !== 32'h0) begin errors++; $display("FAIL done_cfg got arm %b mask %h want 0 0", arm_o, trg_mask_o); end
    drive(0, 1, 40'h02_00000000, 0, 0);
    sent.delete();
    drive(0, 1, 40'h00_00000000, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    checks++;
    if (sent.size() != 1 || sent[0] !== 8'h31 || tx_stb_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_hs got %p stb %b want 31 stb 0", sent, tx_stb_o); end
  endtask
  task automatic test_rst_armed();
    drive(0, 1, 40'hAAAAAAAA_C0, 0, 0);
    drive(0, 1, 40'h00030004_81, 0, 0);
    drive(0, 1, 40'h13_00000000, 0, 0);
    drive(0, 1, 40'h01_00000000, 0, 0);
    drive(1, 1, 40'h00_00000000, 0, 1);
    checks++;
    if ({arm_o, tx_stb_o, busy_o, xoff_o, soft_rst_o, tx_data_o} !== {5'b0, 8'h31} || dut_cfg !== '0)
      begin errors++; $display("FAIL rst_armed got %b %h %h want 00000 31 0", {arm_o, tx_stb_o, busy_o, xoff_o, soft_rst_o}, tx_data_o, dut_cfg); end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (soft_rst_o !== 1'b0) begin errors++; $display("FAIL rst_no_pulse got %b want 0", soft_rst_o); end
  endtask
  task automatic test_random();
    logic [7:0] sops[6] = '{8'h00, 8'h01, 8'h02, 8'h11, 8'h13, 8'h55};
    logic [7:0] lops[7] = '{8'hC0, 8'hC1, 8'hC2, 8'h80, 8'h81, 8'h82, 8'hC5};
    logic [39:0] c;
    logic [7:0] op;
    int k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 19);
      if (k < 9) begin
        op = k == 0 ? 8'h00 : k == 8 ? 8'($urandom) : sops[1 + (k - 1) % 4];
        c = {op, 24'($urandom), 1'b0, 7'($urandom)};
      end else begin
        op = k == 19 ? {1'b1, 7'($urandom)} : lops[k % 6];
        c = {32'($urandom), op};
      end
      drive(0, $urandom_range(0, 1) == 1, c, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
      checks++;
      if (dut_ctl !== exp_ctl()) begin errors++; $display("FAIL rnd_ctl%0d got %h want %h", i, dut_ctl, exp_ctl()); end
      checks++;
      if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL rnd_cfg%0d got %h want %h", i, dut_cfg, exp_cfg()); end
    end
  endtask
  initial begin
    m_clear();
    m_soft = 0;
    test_reset();
    test_config();
    test_id();
    test_arm();
    test_reset_cmd();
    test_simultaneous();
    test_rst_armed();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
